// File: rtl/mcu_sequencer.sv
// Top-level state sequencer for the TurtleMCU core: boot ROM->RAM copy, fetch/execute
// timing, RAM read latency and per-channel IN/OUT handshakes with optional timeout.
module mcu_sequencer #(
  parameter int ROM_DEPTH = 1024,
  parameter int RAM_LAT   = 1,
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 4,
  parameter int TIMEOUT   = 0,
  parameter int ROM_AW    = $clog2(ROM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          op_class,
  input  logic [3:0]          op_chan,
  input  logic                resume,
  input  logic [NUM_IN-1:0]   in_valid,
  output logic [NUM_IN-1:0]   in_ready,
  output logic [NUM_OUT-1:0]  out_valid,
  input  logic [NUM_OUT-1:0]  out_ready,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic                rom_wr,
  output logic                exec,
  output logic                ram_rf_wb,
  output logic                ram_pc_wb,
  output logic                in_wb,
  output logic [3:0]          chan_sel,
  output logic                timeout,
  output logic                chan_err,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_LOAD_ROM  = 4'd1,
    ST_FETCH     = 4'd2,
    ST_EXECUTE   = 4'd3,
    ST_RAM_WAIT  = 4'd4,
    ST_RAM_RD_RF = 4'd5,
    ST_RAM_RD_PC = 4'd6,
    ST_INPUT     = 4'd7,
    ST_OUTPUT    = 4'd8,
    ST_HALT      = 4'd9
  } state_t;

  localparam logic [2:0] OP_RAM_RF = 3'd1;
  localparam logic [2:0] OP_RAM_PC = 3'd2;
  localparam logic [2:0] OP_IN     = 3'd3;
  localparam logic [2:0] OP_OUT    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  // One counter serves fetch latency, RAM wait and handshake timeout; size it for the largest.
  localparam int CNT_MAX   = (TIMEOUT > RAM_LAT) ? ((TIMEOUT > 2) ? TIMEOUT : 2)
                                                 : ((RAM_LAT > 2) ? RAM_LAT : 2);
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int FETCH_END = RAM_LAT - 1;
  localparam int WAIT_END  = (RAM_LAT > 1) ? (RAM_LAT - 2) : 0;
  localparam int TO_END    = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [ROM_AW-1:0] ROM_LAST = ROM_AW'(ROM_DEPTH - 1);

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [3:0]          chan_sel_r, chan_sel_s;
  logic                is_pc_r, is_pc_s;
  logic                timeout_r, timeout_s;
  logic [ROM_AW-1:0]   rom_addr_r, rom_addr_s;
  logic [NUM_IN-1:0]   in_oh_s;
  logic [NUM_OUT-1:0]  out_oh_s;
  logic                in_hs_s, out_hs_s;
  logic                in_chan_ok_s, out_chan_ok_s;

  // Decode the latched channel into one-hot masks and detect handshakes.
  always_comb begin
    in_oh_s  = '0;
    out_oh_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_oh_s[i] = (chan_sel_r == 4'(i));
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      out_oh_s[j] = (chan_sel_r == 4'(j));
    end
    in_hs_s       = |(in_valid & in_oh_s);
    out_hs_s      = |(out_ready & out_oh_s);
    in_chan_ok_s  = ({1'b0, op_chan} < 5'(NUM_IN));
    out_chan_ok_s = ({1'b0, op_chan} < 5'(NUM_OUT));
  end

  // Next-state logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    chan_sel_s = chan_sel_r;
    is_pc_s    = is_pc_r;
    timeout_s  = 1'b0;
    rom_addr_s = rom_addr_r;
    case (state_r)
      ST_RESET: begin
        state_s    = ST_LOAD_ROM;
        rom_addr_s = '0;
      end
      ST_LOAD_ROM: begin
        if (rom_addr_r == ROM_LAST) begin
          state_s = ST_FETCH;
          cnt_s   = '0;
        end else begin
          rom_addr_s = rom_addr_r + ROM_AW'(1);
        end
      end
      ST_FETCH: begin
        if (cnt_r == CW'(FETCH_END)) begin
          state_s = ST_EXECUTE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_EXECUTE: begin
        chan_sel_s = op_chan;
        cnt_s      = '0;
        case (op_class)
          OP_RAM_RF, OP_RAM_PC: begin
            is_pc_s = (op_class == OP_RAM_PC);
            if (RAM_LAT == 1) begin
              state_s = (op_class == OP_RAM_PC) ? ST_RAM_RD_PC : ST_RAM_RD_RF;
            end else begin
              state_s = ST_RAM_WAIT;
            end
          end
          OP_IN:   state_s = in_chan_ok_s ? ST_INPUT : ST_FETCH;
          OP_OUT:  state_s = out_chan_ok_s ? ST_OUTPUT : ST_FETCH;
          OP_HALT: state_s = ST_HALT;
          default: state_s = ST_FETCH;
        endcase
      end
      ST_RAM_WAIT: begin
        if (cnt_r == CW'(WAIT_END)) begin
          state_s = is_pc_r ? ST_RAM_RD_PC : ST_RAM_RD_RF;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_RAM_RD_RF: begin
        // This cycle doubles as the first fetch cycle of the next instruction.
        if (RAM_LAT == 1) begin
          state_s = ST_EXECUTE;
        end else begin
          state_s = ST_FETCH;
          cnt_s   = CW'(1);
        end
      end
      ST_RAM_RD_PC: begin
        state_s = ST_FETCH;
        cnt_s   = '0;
      end
      ST_INPUT, ST_OUTPUT: begin
        // A handshake on the last permitted cycle takes priority over the timeout.
        if ((state_r == ST_INPUT) ? in_hs_s : out_hs_s) begin
          state_s = ST_FETCH;
          cnt_s   = '0;
        end else if ((TIMEOUT > 0) && (cnt_r == CW'(TO_END))) begin
          state_s   = ST_FETCH;
          cnt_s     = '0;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_s = ST_FETCH;
          cnt_s   = '0;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_RESET;
        cnt_s   = '0;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RESET;
      cnt_r      <= '0;
      chan_sel_r <= 4'd0;
      is_pc_r    <= 1'b0;
      timeout_r  <= 1'b0;
      rom_addr_r <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      chan_sel_r <= chan_sel_s;
      is_pc_r    <= is_pc_s;
      timeout_r  <= timeout_s;
      rom_addr_r <= rom_addr_s;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    rom_wr    = (state_r == ST_LOAD_ROM);
    exec      = (state_r == ST_EXECUTE);
    ram_rf_wb = (state_r == ST_RAM_RD_RF);
    ram_pc_wb = (state_r == ST_RAM_RD_PC);
    in_ready  = (state_r == ST_INPUT) ? in_oh_s : '0;
    out_valid = (state_r == ST_OUTPUT) ? out_oh_s : '0;
    in_wb     = (state_r == ST_INPUT) && in_hs_s;
    chan_err  = (state_r == ST_EXECUTE) &&
                (((op_class == OP_IN) && !in_chan_ok_s) ||
                 ((op_class == OP_OUT) && !out_chan_ok_s));
    timeout   = timeout_r;
    chan_sel  = chan_sel_r;
    rom_addr  = rom_addr_r;
    state_o   = state_r;
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Scoreboard bench for mcu_sequencer: two instances (RAM_LAT=1/TIMEOUT=4 and RAM_LAT=3/TIMEOUT=0).
module tb_mcu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] op_class = 3'd0;
  logic [3:0] op_chan = 4'd0;
  logic       resume = 1'b0;
  logic [3:0] in_valid = 4'd0;
  logic [3:0] out_ready = 4'd0;

  logic [3:0] in_ready1, out_valid1, chan_sel1, state1;
  logic [3:0] in_ready2, out_valid2, chan_sel2, state2;
  logic [2:0] rom_addr1, rom_addr2;
  logic rom_wr1, exec1, rf1, pc1, in_wb1, to1, ce1;
  logic rom_wr2, exec2, rf2, pc2, in_wb2, to2, ce2;

  always #5 clk = ~clk;

  mcu_sequencer #(.ROM_DEPTH(8), .RAM_LAT(1), .NUM_IN(4), .NUM_OUT(4), .TIMEOUT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .op_class(op_class), .op_chan(op_chan), .resume(resume),
    .in_valid(in_valid), .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
    .rom_addr(rom_addr1), .rom_wr(rom_wr1), .exec(exec1), .ram_rf_wb(rf1), .ram_pc_wb(pc1),
    .in_wb(in_wb1), .chan_sel(chan_sel1), .timeout(to1), .chan_err(ce1), .state_o(state1));

  mcu_sequencer #(.ROM_DEPTH(8), .RAM_LAT(3), .NUM_IN(4), .NUM_OUT(4), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .op_class(op_class), .op_chan(op_chan), .resume(resume),
    .in_valid(in_valid), .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .rom_addr(rom_addr2), .rom_wr(rom_wr2), .exec(exec2), .ram_rf_wb(rf2), .ram_pc_wb(pc2),
    .in_wb(in_wb2), .chan_sel(chan_sel2), .timeout(to2), .chan_err(ce2), .state_o(state2));

  // Observation word: {state, rom_wr, exec, rf_wb, pc_wb, in_wb, timeout, chan_err, in_ready, out_valid, rom_addr}
  logic [21:0] obs1, obs2;
  assign obs1 = {state1, rom_wr1, exec1, rf1, pc1, in_wb1, to1, ce1, in_ready1, out_valid1, rom_addr1};
  assign obs2 = {state2, rom_wr2, exec2, rf2, pc2, in_wb2, to2, ce2, in_ready2, out_valid2, rom_addr2};

  localparam logic [6:0] SB_0   = 7'b0000000;
  localparam logic [6:0] SB_ROM = 7'b1000000;
  localparam logic [6:0] SB_EX  = 7'b0100000;
  localparam logic [6:0] SB_RF  = 7'b0010000;
  localparam logic [6:0] SB_PC  = 7'b0001000;
  localparam logic [6:0] SB_IW  = 7'b0000100;
  localparam logic [6:0] SB_TO  = 7'b0000010;
  localparam logic [6:0] SB_CE  = 7'b0000001;

  typedef struct {
    logic        rst;
    logic [2:0]  cls;
    logic [3:0]  ch;
    logic        res;
    logic [3:0]  iv;
    logic [3:0]  ordy;
    logic        dsel;
    logic [21:0] exp;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic       rst_v = 1'b0;
  logic [2:0] cls_v = 3'd0;
  logic [3:0] ch_v = 4'd0;
  logic       res_v = 1'b0;
  logic [3:0] iv_v = 4'd0;
  logic [3:0] or_v = 4'd0;
  logic [2:0] addr_v = 3'd0;
  logic       dsel_v = 1'b0;

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d strobes=%b in_ready=%b out_valid=%b addr=%0d, expected state=%0d strobes=%b in_ready=%b out_valid=%b addr=%0d",
               tag, got[21:18], got[17:11], got[10:7], got[6:3], got[2:0],
               exp[21:18], exp[17:11], exp[10:7], exp[6:3], exp[2:0]);
    end
  endtask

  // Queue one cycle: current stimulus settings plus the expected observation.
  task automatic e(input logic [3:0] st, input logic [6:0] stb, input logic [3:0] ir, input logic [3:0] ov);
    item_t it;
    it.rst  = rst_v;
    it.cls  = cls_v;
    it.ch   = ch_v;
    it.res  = res_v;
    it.iv   = iv_v;
    it.ordy = or_v;
    it.dsel = dsel_v;
    it.exp  = {st, stb, ir, ov, addr_v};
    q.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    int idx;
    idx = 0;
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      rst_n     = it.rst;
      op_class  = it.cls;
      op_chan   = it.ch;
      resume    = it.res;
      in_valid  = it.iv;
      out_ready = it.ordy;
      #1;
      check_eq($sformatf("dut%0d_cyc%0d", it.dsel ? 2 : 1, idx), it.dsel ? obs2 : obs1, it.exp);
      idx++;
    end
  endtask

  task automatic boot_seq();
    rst_v = 1'b0; addr_v = 3'd0;
    e(4'd0, SB_0, 4'd0, 4'd0);
    e(4'd0, SB_0, 4'd0, 4'd0);
    rst_v = 1'b1;
    e(4'd0, SB_0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      addr_v = 3'(i);
      e(4'd1, SB_ROM, 4'd0, 4'd0);
    end
  endtask

  initial begin
    // Instance 1: RAM_LAT=1, TIMEOUT=4
    dsel_v = 1'b0;
    boot_seq();
    e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd0; e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd1; e(4'd3, SB_EX, 4'd0, 4'd0);
    cls_v = 3'd0; e(4'd5, SB_RF, 4'd0, 4'd0);
    e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd2; e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd6, SB_PC, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd3; ch_v = 4'd2; e(4'd3, SB_EX, 4'd0, 4'd0);
    iv_v = 4'b0010;
    for (int i = 0; i < 3; i++) e(4'd7, SB_0, 4'b0100, 4'd0);
    iv_v = 4'b0110; e(4'd7, SB_IW, 4'b0100, 4'd0);
    iv_v = 4'b0000; e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd4; ch_v = 4'd1; e(4'd3, SB_EX, 4'd0, 4'd0);
    or_v = 4'b1101;
    for (int i = 0; i < 4; i++) e(4'd8, SB_0, 4'd0, 4'b0010);
    or_v = 4'b0000; e(4'd2, SB_TO, 4'd0, 4'd0);
    ch_v = 4'd9; e(4'd3, SB_EX | SB_CE, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    ch_v = 4'd3; e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd8, SB_0, 4'd0, 4'b1000);
    or_v = 4'b1000; e(4'd8, SB_0, 4'd0, 4'b1000);
    or_v = 4'b0000; e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd3; ch_v = 4'd5; e(4'd3, SB_EX | SB_CE, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    ch_v = 4'd0; e(4'd3, SB_EX, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) e(4'd7, SB_0, 4'b0001, 4'd0);
    e(4'd2, SB_TO, 4'd0, 4'd0);
    cls_v = 3'd5; e(4'd3, SB_EX, 4'd0, 4'd0);
    cls_v = 3'd0;
    e(4'd9, SB_0, 4'd0, 4'd0);
    e(4'd9, SB_0, 4'd0, 4'd0);
    res_v = 1'b1; e(4'd9, SB_0, 4'd0, 4'd0);
    res_v = 1'b0; e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd6; e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd4; ch_v = 4'd2; e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd8, SB_0, 4'd0, 4'b0100);
    rst_v = 1'b0; addr_v = 3'd0; e(4'd0, SB_0, 4'd0, 4'd0);
    drain();

    // Instance 2: RAM_LAT=3, TIMEOUT=0
    dsel_v = 1'b1; cls_v = 3'd0; ch_v = 4'd0;
    boot_seq();
    for (int i = 0; i < 3; i++) e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd2; e(4'd3, SB_EX, 4'd0, 4'd0);
    cls_v = 3'd0;
    e(4'd4, SB_0, 4'd0, 4'd0);
    e(4'd4, SB_0, 4'd0, 4'd0);
    e(4'd6, SB_PC, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd1; e(4'd3, SB_EX, 4'd0, 4'd0);
    cls_v = 3'd0;
    e(4'd4, SB_0, 4'd0, 4'd0);
    e(4'd4, SB_0, 4'd0, 4'd0);
    e(4'd5, SB_RF, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    cls_v = 3'd3; ch_v = 4'd2; e(4'd3, SB_EX, 4'd0, 4'd0);
    cls_v = 3'd0; iv_v = 4'b0010;
    for (int i = 0; i < 4; i++) e(4'd7, SB_0, 4'b0100, 4'd0);
    iv_v = 4'b0100; e(4'd7, SB_IW, 4'b0100, 4'd0);
    iv_v = 4'b0000;
    for (int i = 0; i < 3; i++) e(4'd2, SB_0, 4'd0, 4'd0);
    e(4'd3, SB_EX, 4'd0, 4'd0);
    e(4'd2, SB_0, 4'd0, 4'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
